// File: rtl/dump_pkg.sv
// rtl/dump_pkg.sv - shared types and constants for the state dump unit
//
// Purpose : state encoding for the dump FSM and beat tag values.
//           The DUMP_SUM state exists only when DUMP_CHECKSUM_EN is defined.
// Ports   : none (package)
package dump_pkg;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        DUMP_REG = 3'd1,
        DUMP_MEM = 3'd2,
`ifdef DUMP_CHECKSUM_EN
        DUMP_SUM = 3'd3,
`endif
        DRAIN    = 3'd4,
        DONE     = 3'd5
    } dump_state_t;

    localparam logic [1:0] TAG_REG = 2'd0;
    localparam logic [1:0] TAG_MEM = 2'd1;
    localparam logic [1:0] TAG_SUM = 2'd2;

    localparam int IDX_W = 8;

endpackage

// File: rtl/dump_out_reg.sv
// rtl/dump_out_reg.sv - dump beat holding register with valid/ready hold logic
//
// Purpose : holds one {tag, idx, data} beat. A load writes a new beat and
//           raises valid; a clear drops valid once the last beat is taken.
//           Payload never changes unless loaded, so it is stable under stall.
// Ports   : clk, rst      - clock, synchronous active-high reset
//           i_load        - capture i_tag/i_idx/i_data, set valid
//           i_clear       - drop valid (final beat accepted)
//           i_tag/i_idx/i_data - incoming beat
//           o_valid/o_tag/o_idx/o_data - registered beat
module dump_out_reg #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_clear,
    input  logic [1:0]      i_tag,
    input  logic [7:0]      i_idx,
    input  logic [XLEN-1:0] i_data,
    output logic            o_valid,
    output logic [1:0]      o_tag,
    output logic [7:0]      o_idx,
    output logic [XLEN-1:0] o_data
);

    logic            r_valid;
    logic [1:0]      r_tag;
    logic [7:0]      r_idx;
    logic [XLEN-1:0] r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_tag   <= 2'd0;
            r_idx   <= 8'd0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_tag   <= i_tag;
            r_idx   <= i_idx;
            r_data  <= i_data;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_tag   = r_tag;
    assign o_idx   = r_idx;
    assign o_data  = r_data;

endmodule

// File: rtl/state_dump_unit.sv
// rtl/state_dump_unit.sv - end-of-run halt/timeout observer and state dumper
//
// Purpose : watches the core PC; on a halt (PC stuck) or cycle-budget timeout
//           it freezes the core and streams the register file then a data
//           memory window over a valid/ready port. Define DUMP_CHECKSUM_EN to
//           append an XOR checksum beat after the memory beats.
// Ports   : clk, rst           - clock, synchronous active-high reset
//           pc_i               - core PC
//           rf_raddr_o/rf_rdata_i - combinational register-file read port
//           dm_raddr_o/dm_rdata_i - combinational data-memory read port
//           core_halt_o        - freeze core (high outside RUN)
//           dump_valid_o/dump_ready_i - beat handshake
//           dump_tag_o/dump_idx_o/dump_data_o - beat payload
//           timeout_o          - dump caused by cycle budget
//           cycles_o           - cycle index latched at trigger
//           done_o             - all beats accepted
module state_dump_unit
    import dump_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int NREGS       = 32,
    parameter int DM_AW       = 10,
    parameter int DMEM_BASE   = 0,
    parameter int DMEM_WORDS  = 16,
    parameter int STALL_LIMIT = 4,
    parameter int CYCLE_LIMIT = 280,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  pc_i,
    output logic [4:0]       rf_raddr_o,
    input  logic [XLEN-1:0]  rf_rdata_i,
    output logic [DM_AW-1:0] dm_raddr_o,
    input  logic [XLEN-1:0]  dm_rdata_i,
    output logic             core_halt_o,
    output logic             dump_valid_o,
    input  logic             dump_ready_i,
    output logic [1:0]       dump_tag_o,
    output logic [7:0]       dump_idx_o,
    output logic [XLEN-1:0]  dump_data_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] cycles_o,
    output logic             done_o
);

    dump_state_t r_state;
    dump_state_t w_next;

    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [XLEN-1:0]  r_pc_q;
    logic             r_first;
    logic             r_timeout;
    logic [CNT_W-1:0] r_cycles;
    logic [IDX_W-1:0] r_idx;

    logic             w_run;
    logic             w_pc_eq;
    logic             w_halt_trig;
    logic             w_tmo_trig;
    logic             w_trigger;
    logic             w_in_dump;
    logic             w_load;
    logic             w_clear;
    logic             w_last_reg;
    logic             w_last_mem;
    logic [1:0]       w_beat_tag;
    logic [7:0]       w_beat_idx;
    logic [XLEN-1:0]  w_beat_data;

`ifdef DUMP_CHECKSUM_EN
    logic [XLEN-1:0]  r_csum;
`endif

    // ---------------- trigger detection ----------------
    assign w_run       = (r_state == RUN);
    // First RUN cycle has no valid previous PC to compare against.
    assign w_pc_eq     = w_run && !r_first && (pc_i == r_pc_q);
    assign w_halt_trig = w_pc_eq && (r_stall_cnt == CNT_W'(STALL_LIMIT - 1));
    assign w_tmo_trig  = w_run && (r_cycle_cnt == CNT_W'(CYCLE_LIMIT - 1));
    assign w_trigger   = w_halt_trig || w_tmo_trig;

    // ---------------- dump engine controls ----------------
`ifdef DUMP_CHECKSUM_EN
    assign w_in_dump = (r_state == DUMP_REG) || (r_state == DUMP_MEM) ||
                       (r_state == DUMP_SUM);
`else
    assign w_in_dump = (r_state == DUMP_REG) || (r_state == DUMP_MEM);
`endif
    // Output slot is free when empty or its beat is being taken this cycle.
    assign w_load     = w_in_dump && (!dump_valid_o || dump_ready_i);
    assign w_clear    = (r_state == DRAIN) && dump_valid_o && dump_ready_i;
    assign w_last_reg = (r_idx == IDX_W'(NREGS - 1));
    assign w_last_mem = (r_idx == IDX_W'(DMEM_WORDS - 1));

    assign rf_raddr_o = r_idx[4:0];
    assign dm_raddr_o = DM_AW'(DMEM_BASE) + DM_AW'(r_idx);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            RUN: begin
                if (w_trigger) w_next = DUMP_REG;
            end
            DUMP_REG: begin
                if (w_load && w_last_reg) w_next = DUMP_MEM;
            end
            DUMP_MEM: begin
                if (w_load && w_last_mem) begin
`ifdef DUMP_CHECKSUM_EN
                    w_next = DUMP_SUM;
`else
                    w_next = DRAIN;
`endif
                end
            end
`ifdef DUMP_CHECKSUM_EN
            DUMP_SUM: begin
                if (w_load) w_next = DRAIN;
            end
`endif
            DRAIN: begin
                if (w_clear) w_next = DONE;
            end
            DONE: begin
                w_next = DONE;
            end
            default: begin
                w_next = RUN;
            end
        endcase
    end

    // ---------------- FSM: outputs / beat mux ----------------
    always_comb begin
        core_halt_o = (r_state != RUN);
        done_o      = (r_state == DONE);
        w_beat_tag  = TAG_REG;
        w_beat_idx  = r_idx;
        w_beat_data = rf_rdata_i;
        case (r_state)
            DUMP_MEM: begin
                w_beat_tag  = TAG_MEM;
                w_beat_data = dm_rdata_i;
            end
`ifdef DUMP_CHECKSUM_EN
            DUMP_SUM: begin
                w_beat_tag  = TAG_SUM;
                w_beat_idx  = 8'd0;
                w_beat_data = r_csum;
            end
`endif
            default: begin
                w_beat_tag  = TAG_REG;
            end
        endcase
    end

    // ---------------- RUN-phase counters ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_cnt <= '0;
            r_stall_cnt <= '0;
            r_pc_q      <= '0;
            r_first     <= 1'b1;
            r_timeout   <= 1'b0;
            r_cycles    <= '0;
        end else if (w_run) begin
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            r_pc_q      <= pc_i;
            r_first     <= 1'b0;
            r_stall_cnt <= w_pc_eq ? (r_stall_cnt + CNT_W'(1)) : '0;
            if (w_trigger) begin
                r_cycles  <= r_cycle_cnt;
                // A halt on the same cycle as the budget expiry is a halt.
                r_timeout <= !w_halt_trig;
            end
        end
    end

    // ---------------- beat index ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
        end else if (w_load) begin
            if ((r_state == DUMP_REG) && w_last_reg) begin
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

`ifdef DUMP_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_csum <= '0;
        end else if (w_load && (r_state != DUMP_SUM)) begin
            r_csum <= r_csum ^ w_beat_data;
        end
    end
`endif

    assign timeout_o = r_timeout;
    assign cycles_o  = r_cycles;

    dump_out_reg #(
        .XLEN (XLEN)
    ) u_out (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_clear (w_clear),
        .i_tag   (w_beat_tag),
        .i_idx   (w_beat_idx),
        .i_data  (w_beat_data),
        .o_valid (dump_valid_o),
        .o_tag   (dump_tag_o),
        .o_idx   (dump_idx_o),
        .o_data  (dump_data_o)
    );

endmodule

// File: tb/tb_state_dump_unit.sv
// tb/tb_state_dump_unit.sv - directed self-checking bench for state_dump_unit
module tb_state_dump_unit;

`ifdef DUMP_CHECKSUM_EN
    localparam int NBEATS = 49;
`else
    localparam int NBEATS = 48;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic [9:0]  dm_raddr;
    logic [31:0] dm_rdata;
    logic        core_halt;
    logic        dump_valid;
    logic        dump_ready;
    logic [1:0]  dump_tag;
    logic [7:0]  dump_idx;
    logic [31:0] dump_data;
    logic        timeout;
    logic [15:0] cycles;
    logic        done;

    logic [31:0] rf_m  [32];
    logic [31:0] mem_m [1024];

    int n_assert = 0;
    int n_fail   = 0;
    int acc, cyc;
    logic [1:0]  last_tag;
    logic [31:0] last_data;

    always #5 clk = ~clk;

    assign rf_rdata = rf_m[rf_raddr];
    assign dm_rdata = mem_m[dm_raddr];

    state_dump_unit #(
        .XLEN(32), .NREGS(32), .DM_AW(10), .DMEM_BASE(0), .DMEM_WORDS(16),
        .STALL_LIMIT(4), .CYCLE_LIMIT(64), .CNT_W(16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc),
        .rf_raddr_o   (rf_raddr),
        .rf_rdata_i   (rf_rdata),
        .dm_raddr_o   (dm_raddr),
        .dm_rdata_i   (dm_rdata),
        .core_halt_o  (core_halt),
        .dump_valid_o (dump_valid),
        .dump_ready_i (dump_ready),
        .dump_tag_o   (dump_tag),
        .dump_idx_o   (dump_idx),
        .dump_data_o  (dump_data),
        .timeout_o    (timeout),
        .cycles_o     (cycles),
        .done_o       (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] csum_model();
        logic [31:0] s = 32'd0;
        for (int i = 0; i < 32; i++) s = s ^ rf_m[i];
        for (int k = 0; k < 16; k++) s = s ^ mem_m[k];
        return s;
    endfunction

    function automatic logic [41:0] exp_beat(input int k);
        if (k < 32)      return {2'd0, 8'(k), rf_m[k]};
        else if (k < 48) return {2'd1, 8'(k - 32), mem_m[k - 32]};
        else             return {2'd2, 8'd0, csum_model()};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Collect beats; toggle=1 drives ready 1,0,1,0...; stop_at>=0 stops early.
    task automatic drain(input bit toggle, input int stop_at, output int n_acc, output int n_cyc);
        logic [41:0] held_beat;
        bit held;
        bit rdy;
        n_acc = 0;
        n_cyc = 0;
        held  = 1'b0;
        rdy   = 1'b1;
        held_beat = '0;
        while (n_acc < NBEATS && n_cyc < 400 && !(stop_at >= 0 && n_acc == stop_at)) begin
            dump_ready = rdy;
            if (held) check("stall_hold", {dump_valid, dump_tag, dump_idx, dump_data}, {1'b1, held_beat});
            if (dump_valid && rdy) begin
                check($sformatf("beat%0d", n_acc), {dump_tag, dump_idx, dump_data}, exp_beat(n_acc));
                if (n_acc == NBEATS - 1) check("done_before_last", done, 1'b0);
                last_tag  = dump_tag;
                last_data = dump_data;
                n_acc++;
                held = 1'b0;
            end else if (dump_valid) begin
                held = 1'b1;
                held_beat = {dump_tag, dump_idx, dump_data};
            end
            step();
            n_cyc++;
            if (toggle) rdy = !rdy;
        end
        dump_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++)   rf_m[i]  = 32'(i);
        for (int k = 0; k < 1024; k++) mem_m[k] = 32'h100 + 32'(k);
        rst = 1'b1;
        pc = 32'd0;
        dump_ready = 1'b0;
        step();
        do_reset();

        // Reset state
        check("rst_halt",    core_halt,  1'b0);
        check("rst_valid",   dump_valid, 1'b0);
        check("rst_payload", {dump_tag, dump_idx, dump_data}, 42'd0);
        check("rst_timeout", timeout,    1'b0);
        check("rst_cycles",  cycles,     16'd0);
        check("rst_done",    done,       1'b0);
        check("rst_rfaddr",  rf_raddr,   5'd0);
        check("rst_dmaddr",  dm_raddr,   10'd0);

        // Halt: pc = 4n for n=0..16, then held at 0x40 -> trigger at cycle 20
        for (int n = 1; n <= 16; n++) begin
            step();
            pc = 32'(4 * n);
        end
        repeat (4) step();
        check("halt_not_yet", core_halt, 1'b0);
        step();
        check("halt_rise",    core_halt, 1'b1);
        check("halt_cycles",  cycles,    16'd20);
        check("halt_timeout", timeout,   1'b0);
        check("halt_valid0",  dump_valid, 1'b0);

        // Stream order under ready toggling 1,0,1,0
        drain(1'b1, -1, acc, cyc);
        check("bp_beats",    acc,        NBEATS);
        check("bp_done",     done,       1'b1);
        check("bp_valid_lo", dump_valid, 1'b0);
        step();
        check("done_sticky", {done, core_halt}, 2'b11);

        // Reset mid-dump: constant PC -> trigger at cycle 4
        do_reset();
        pc = 32'h80;
        repeat (4) step();
        check("r2_not_yet", core_halt, 1'b0);
        step();
        check("r2_halt",   core_halt, 1'b1);
        check("r2_cycles", cycles,    16'd4);
        drain(1'b0, 11, acc, cyc);
        check("r2_acc", acc, 11);
        rst = 1'b1;
        step();
        check("mid_rst_valid", dump_valid, 1'b0);
        check("mid_rst_halt",  core_halt,  1'b0);
        check("mid_rst_out",   {done, timeout, cycles, dump_tag, dump_idx, dump_data}, 60'd0);
        rst = 1'b0;

        // Timeout: PC increments every cycle, budget 64 -> cycles_o 63
        pc = 32'd0;
        for (int n = 1; n <= 63; n++) begin
            step();
            pc = 32'(4 * n);
        end
        check("tmo_not_yet", core_halt, 1'b0);
        step();
        check("tmo_halt",    core_halt, 1'b1);
        check("tmo_flag",    timeout,   1'b1);
        check("tmo_cycles",  cycles,    16'd63);
        drain(1'b0, -1, acc, cyc);
        check("tmo_beats",      acc,  NBEATS);
        check("tmo_throughput", cyc,  NBEATS + 1);
        check("tmo_done",       done, 1'b1);

        // Simultaneous halt and budget expiry at cycle 63 -> halt wins
        do_reset();
        pc = 32'd0;
        for (int n = 1; n <= 63; n++) begin
            step();
            pc = (n < 59) ? 32'(4 * n) : 32'(4 * 59);
        end
        check("sim_not_yet", core_halt, 1'b0);
        step();
        check("sim_halt",    core_halt, 1'b1);
        check("sim_timeout", timeout,   1'b0);
        check("sim_cycles",  cycles,    16'd63);

`ifdef DUMP_CHECKSUM_EN
        // Checksum: only mem[3] nonzero, registers XOR to zero
        for (int k = 0; k < 1024; k++) mem_m[k] = 32'd0;
        mem_m[3] = 32'hDEADBEEF;
        do_reset();
        pc = 32'h200;
        repeat (5) step();
        check("cs_halt", core_halt, 1'b1);
        drain(1'b0, -1, acc, cyc);
        check("cs_beats", acc, 49);
        check("cs_last",  {last_tag, last_data}, {2'd2, 32'hDEADBEEF});
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
